// File: rtl/inst_fetch_unit_if.sv
// Fetch-side bus: ROM port, fetch/redirect control and IF/ID handshake.
interface inst_fetch_unit_if;
  localparam int unsigned AW = 6;
  localparam int unsigned IW = 32;

  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_inst;
  logic          fetch_en;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          id_ready;
  logic          if_valid;
  logic [IW-1:0] if_inst;
  logic [AW-1:0] if_pc;

  // Fetch unit side: drives the ROM address and the IF/ID payload.
  modport master (
    output rom_addr,
    input  rom_inst,
    input  fetch_en,
    input  redirect_valid,
    input  redirect_pc,
    input  id_ready,
    output if_valid,
    output if_inst,
    output if_pc
  );

  // Environment side: ROM, execute-stage redirect and decode.
  modport slave (
    input  rom_addr,
    output rom_inst,
    output fetch_en,
    output redirect_valid,
    output redirect_pc,
    output id_ready,
    input  if_valid,
    input  if_inst,
    input  if_pc
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: PC, local jump resolution, 2-entry prefetch queue
// presented to decode through a valid/ready handshake.
module inst_fetch_unit #(
  parameter logic [5:0] RESET_PC    = 6'h01,
  parameter logic [5:0] JUMP_OPCODE = 6'b010010
) (
  input  logic              clk,
  input  logic              rst_n,
  inst_fetch_unit_if.master bus
);
  localparam int unsigned AW    = 6;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 2;

  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] qpc_q   [DEPTH];
  logic [IW-1:0] qinst_q [DEPTH];

  logic pop_c;
  logic push_c;
  logic is_jump_c;
  logic head_valid_c;

  // Handshake qualifiers; redirect suppresses the push and flushes the queue.
  always_comb begin
    head_valid_c = (cnt_q != CW'(0));
    pop_c        = head_valid_c & bus.id_ready;
    push_c       = bus.fetch_en & ~bus.redirect_valid &
                   ((cnt_q < CW'(DEPTH)) | pop_c);
    is_jump_c    = (bus.rom_inst[31:26] == JUMP_OPCODE);
  end

  // Next-state for PC, occupancy and pointers.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    if (bus.redirect_valid) begin
      pc_d  = bus.redirect_pc;
      cnt_d = '0;
      rd_d  = 1'b0;
      wr_d  = 1'b0;
    end else begin
      if (push_c) begin
        pc_d = is_jump_c ? bus.rom_inst[AW-1:0] : pc_q + AW'(1);
        wr_d = ~wr_q;
      end
      if (pop_c) begin
        rd_d = ~rd_q;
      end
      case ({push_c, pop_c})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
    end
  end

  // Queue storage: the fetched word is written at the tail together with its PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        qpc_q[i]   <= '0;
        qinst_q[i] <= '0;
      end
    end else if (push_c) begin
      qpc_q[wr_q]   <= pc_q;
      qinst_q[wr_q] <= bus.rom_inst;
    end
  end

  // Outputs derive from registered state only; payload reads zero when empty.
  assign bus.rom_addr = pc_q;
  assign bus.if_valid = head_valid_c;
  assign bus.if_inst  = head_valid_c ? qinst_q[rd_q] : '0;
  assign bus.if_pc    = head_valid_c ? qpc_q[rd_q]   : '0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a combinational ROM model.
module tb_inst_fetch_unit;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  logic [31:0] rom [64];

  inst_fetch_unit_if bus ();

  inst_fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.rom_inst = rom[bus.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [5:0] pc, input logic [31:0] inst);
    check_eq({tag, "_valid"}, 32'(bus.if_valid), 32'd1);
    check_eq({tag, "_pc"},    32'(bus.if_pc),    32'(pc));
    check_eq({tag, "_inst"},  bus.if_inst,       inst);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0100 + 32'(i);
    rom[6'h00] = 32'h0;
    rom[6'h01] = 32'h3800_0866;
    rom[6'h02] = 32'h3400_0481;
    rom[6'h0B] = 32'h2800_0461;
    rom[6'h0C] = 32'h1400_0901;
    rom[6'h12] = 32'h4800_0001;
    rom[6'h3F] = 32'h0;

    rst_n              = 1'b0;
    bus.fetch_en       = 1'b0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 6'h00;

    // Reset state
    #12;
    check_eq("rst_rom_addr", 32'(bus.rom_addr), 32'h01);
    check_eq("rst_valid",    32'(bus.if_valid), 32'd0);
    check_eq("rst_inst",     bus.if_inst,       32'h0);
    check_eq("rst_pc",       32'(bus.if_pc),    32'h0);

    // First fetch
    rst_n = 1'b1; bus.fetch_en = 1'b1; bus.id_ready = 1'b1;
    step(); check_head("first1", 6'h01, 32'h3800_0866);
    step(); check_head("first2", 6'h02, 32'h3400_0481);

    // Backpressure after a fresh reset
    rst_n = 1'b0; bus.id_ready = 1'b0; #2; rst_n = 1'b1;
    step(); check_head("bp_s1", 6'h01, 32'h3800_0866);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bp_hold_pc",   32'(bus.if_pc),    32'h01);
      check_eq("bp_rom_addr",  32'(bus.rom_addr), 32'h03);
    end
    bus.id_ready = 1'b1;
    step(); check_head("bp_r2", 6'h02, 32'h3400_0481);
    step(); check_eq("bp_r3", 32'(bus.if_pc), 32'h03);
    step(); check_eq("bp_r4", 32'(bus.if_pc), 32'h04);

    // Redirect while full and popping (count stays 2 under push+pop)
    bus.redirect_valid = 1'b1; bus.redirect_pc = 6'h0B;
    step();
    check_eq("rd_valid",    32'(bus.if_valid), 32'd0);
    check_eq("rd_rom_addr", 32'(bus.rom_addr), 32'h0B);
    bus.redirect_valid = 1'b0;
    step(); check_head("rd_0b", 6'h0B, 32'h2800_0461);
    step(); check_head("rd_0c", 6'h0C, 32'h1400_0901);

    // Local jump at 0x12 to 0x01
    bus.redirect_valid = 1'b1; bus.redirect_pc = 6'h12;
    step(); check_eq("jmp_flush", 32'(bus.if_valid), 32'd0);
    bus.redirect_valid = 1'b0;
    step();
    check_head("jmp_12", 6'h12, 32'h4800_0001);
    check_eq("jmp_rom_addr", 32'(bus.rom_addr), 32'h01);
    step(); check_head("jmp_01", 6'h01, 32'h3800_0866);
    step(); check_head("jmp_02", 6'h02, 32'h3400_0481);

    // Wrap-around
    bus.redirect_valid = 1'b1; bus.redirect_pc = 6'h3F;
    step();
    bus.redirect_valid = 1'b0;
    step(); check_head("wrap_3f", 6'h3F, 32'h0);
    step(); check_head("wrap_00", 6'h00, 32'h0);
    step(); check_head("wrap_01", 6'h01, 32'h3800_0866);

    // fetch_en gating: fill to 2, then drain with fetch disabled
    bus.id_ready = 1'b0;
    step(); step();
    check_eq("gate_full_addr", 32'(bus.rom_addr), 32'h03);
    bus.fetch_en = 1'b0; bus.id_ready = 1'b1;
    step(); check_head("gate_d1", 6'h02, 32'h3400_0481);
    step(); check_eq("gate_d2_valid", 32'(bus.if_valid), 32'd0);
    step(); check_eq("gate_d3_valid", 32'(bus.if_valid), 32'd0);
    check_eq("gate_pc_hold", 32'(bus.rom_addr), 32'h03);

    // Async reset mid-cycle while full
    bus.fetch_en = 1'b1; bus.id_ready = 1'b0;
    step(); step();
    check_eq("ar_pre_valid", 32'(bus.if_valid), 32'd1);
    #2; rst_n = 1'b0; #1;
    check_eq("ar_valid",    32'(bus.if_valid), 32'd0);
    check_eq("ar_rom_addr", 32'(bus.rom_addr), 32'h01);
    #1; rst_n = 1'b1; bus.id_ready = 1'b1;
    step(); check_head("ar_first", 6'h01, 32'h3800_0866);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
